qdec_counter: RTL and testbench

- Quadrature decoder and position counter: the receive end of the quadrature A/B/Z stream that the encoder-output block drives.
- Synchronises and deglitches the A, B and Z inputs, then decodes Gray-code transitions into up/down steps.
- Maintains a 32-bit position with set-point load and optional reset-on-Z.
- Sits in the encoder-input path. out_o feeds the position bus, in the same way posn_i feeds the encoder output.

---
 rtl/qdec_pkg.sv | 42 ++++
 rtl/qdec_filter.sv | 42 ++++
 rtl/qdec_counter.sv | 113 +++++++++++
 tb/tb_qdec_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature decoder: AB Gray states,
// decode result encoding and the up-sequence successor function.
package qdec_pkg;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

  localparam int unsigned FILT_BITS_DEF = 4;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DOWN = 2'd2,
    DEC_ERR  = 2'd3
  } dec_t;

  // Successor of an AB state along the up sequence 00->10->11->01->00.
  function automatic logic [1:0] up_next(input logic [1:0] s);
    logic [1:0] n;
    n = AB_00;
    case (s)
      AB_00: n = AB_10;
      AB_10: n = AB_11;
      AB_11: n = AB_01;
      AB_01: n = AB_00;
      default: n = AB_00;
    endcase
    return n;
  endfunction

  function automatic dec_t decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_t d;
    if (prev == cur)                d = DEC_NONE;
    else if (cur == up_next(prev))  d = DEC_UP;
    else if (prev == up_next(cur))  d = DEC_DOWN;
    else                            d = DEC_ERR;
    return d;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Synchroniser plus glitch filter for one asynchronous quadrature pin.
// The output follows the synchronised pin after it differs for filter+1 cycles.
module qdec_filter
  import qdec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_BITS   = FILT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin,
  input  logic [FILT_BITS-1:0] filter,
  output logic                 out
);

  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_BITS-1:0]   cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      out  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      if (synced != out) begin
        if (cnt == filter) begin
          out <= synced;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/qdec_counter.sv
// Quadrature decoder and 32-bit position counter with set-point load and
// optional reset-on-Z. Define QDEC_PERIOD_EN to add the step interval output.
module qdec_counter
  import qdec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_BITS   = FILT_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 z_i,
  input  logic                 enable_i,
  input  logic [FILT_BITS-1:0] FILTER,
  input  logic [31:0]          SETP,
  input  logic                 SETP_WSTB,
  input  logic                 RST_ON_Z,
  output logic [31:0]          out_o,
  output logic                 step_o,
  output logic                 dir_o,
  output logic                 err_o
`ifdef QDEC_PERIOD_EN
  ,
  output logic [31:0]          period_o
`endif
);

  logic       a_f, b_f, z_f;
  logic [1:0] cur_ab, prev_ab;
  logic       z_prev;
  logic       primed;
  logic [31:0] prime_cnt, prime_len;
  dec_t       dec;
  logic       step_now, z_rise;

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_BITS(FILT_BITS)) u_filt_a (
    .clk(clk_i), .rst(reset_i), .pin(a_i), .filter(FILTER), .out(a_f)
  );
  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_BITS(FILT_BITS)) u_filt_b (
    .clk(clk_i), .rst(reset_i), .pin(b_i), .filter(FILTER), .out(b_f)
  );
  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_BITS(FILT_BITS)) u_filt_z (
    .clk(clk_i), .rst(reset_i), .pin(z_i), .filter(FILTER), .out(z_f)
  );

  assign cur_ab = {a_f, b_f};

  // Priming spans until the filtered value of a level held through reset has
  // landed in prev_ab, so a non-zero idle AB never reads as a transition.
  assign prime_len = 32'(SYNC_STAGES) + 32'd2 + 32'(FILTER);

  always_comb begin
    dec      = DEC_NONE;
    step_now = 1'b0;
    z_rise   = 1'b0;
    if (primed) begin
      dec      = decode(prev_ab, cur_ab);
      step_now = enable_i && ((dec == DEC_UP) || (dec == DEC_DOWN));
      z_rise   = z_f && !z_prev;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_ab   <= AB_00;
      z_prev    <= 1'b0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      out_o     <= '0;
      step_o    <= 1'b0;
      dir_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      z_prev  <= z_f;
      if (!primed) begin
        prime_cnt <= prime_cnt + 32'd1;
        if (prime_cnt + 32'd1 >= prime_len) primed <= 1'b1;
      end
      step_o <= step_now;
      if (step_now) dir_o <= (dec == DEC_UP);
      if (SETP_WSTB) begin
        out_o <= SETP;
        err_o <= 1'b0;
      end else begin
        if (dec == DEC_ERR) err_o <= 1'b1;
        if (RST_ON_Z && enable_i && z_rise) out_o <= '0;
        else if (step_now) out_o <= (dec == DEC_UP) ? out_o + 32'd1 : out_o - 32'd1;
      end
    end
  end

`ifdef QDEC_PERIOD_EN
  logic [31:0] ivl;
  logic [31:0] ivl_inc;

  assign ivl_inc = (ivl == '1) ? ivl : ivl + 32'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ivl      <= '0;
      period_o <= '0;
    end else if (step_now) begin
      period_o <= ivl_inc;
      ivl      <= '0;
    end else begin
      ivl      <= ivl_inc;
    end
  end
`endif

endmodule

// File: tb/tb_qdec_counter.sv
// Directed self-checking bench for qdec_counter; covers the period output
// when compiled with QDEC_PERIOD_EN.
module tb_qdec_counter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        a_i, b_i, z_i, enable_i;
  logic [3:0]  FILTER;
  logic [31:0] SETP;
  logic        SETP_WSTB, RST_ON_Z;
  logic [31:0] out_o;
  logic        step_o, dir_o, err_o;
`ifdef QDEC_PERIOD_EN
  logic [31:0] period_o;
`endif

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [1:0] cur_ab;

  always #5 clk_i = ~clk_i;

  qdec_counter #(.SYNC_STAGES(2), .FILT_BITS(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .z_i(z_i),
    .enable_i(enable_i), .FILTER(FILTER), .SETP(SETP), .SETP_WSTB(SETP_WSTB),
    .RST_ON_Z(RST_ON_Z), .out_o(out_o), .step_o(step_o), .dir_o(dir_o),
    .err_o(err_o)
`ifdef QDEC_PERIOD_EN
    , .period_o(period_o)
`endif
  );

  always @(negedge clk_i) if (step_o === 1'b1) pulses++;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00: return 2'b10;
      2'b10: return 2'b11;
      2'b11: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive one transition just after an edge; step_o must appear lat ticks later.
  task automatic do_step(input bit up, input int unsigned lat, input bit exp_step,
                         input int unsigned gap, input string tag);
    cur_ab = up ? fwd(cur_ab) : rev(cur_ab);
    a_i = cur_ab[1];
    b_i = cur_ab[0];
    tick(lat - 1);
    chk({tag, "_early"}, {31'd0, step_o}, 32'd0);
    tick(1);
    chk({tag, "_step"}, {31'd0, step_o}, {31'd0, exp_step});
    tick(gap - lat);
  endtask

  initial begin
    reset_i = 1'b1; a_i = 1'b1; b_i = 1'b1; z_i = 1'b0; enable_i = 1'b1;
    FILTER = 4'd0; SETP = '0; SETP_WSTB = 1'b0; RST_ON_Z = 1'b0;
    cur_ab = 2'b11;
    tick(3);
    chk("rst_out", out_o, 32'd0);
    chk("rst_flags", {29'd0, step_o, dir_o, err_o}, 32'd0);
`ifdef QDEC_PERIOD_EN
    chk("rst_period", period_o, 32'd0);
`endif
    reset_i = 1'b0;
    tick(12);
    chk("prime_err", {31'd0, err_o}, 32'd0);
    chk("prime_out", out_o, 32'd0);
    chk("prime_pulses", pulses, 0);

    for (int i = 0; i < 8; i++) do_step(1'b1, 4, 1'b1, 20, "up");
    chk("up_out", out_o, 32'd8);
    chk("up_dir", {31'd0, dir_o}, 32'd1);
    chk("up_pulses", pulses, 8);
    for (int i = 0; i < 3; i++) do_step(1'b0, 4, 1'b1, 20, "dn");
    chk("dn_out", out_o, 32'd5);
    chk("dn_dir", {31'd0, dir_o}, 32'd0);

    SETP = 32'hFFFF_FFFE; SETP_WSTB = 1'b1; tick(1); SETP_WSTB = 1'b0; tick(1);
    chk("setp_load", out_o, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) do_step(1'b1, 4, 1'b1, 20, "wrap");
    chk("wrap_out", out_o, 32'h0000_0001);

    // Set-point strobe lands on the same edge as the step's count update.
    cur_ab = fwd(cur_ab); a_i = cur_ab[1]; b_i = cur_ab[0];
    tick(3);
    SETP = 32'h1234_5678; SETP_WSTB = 1'b1;
    tick(1);
    SETP_WSTB = 1'b0;
    chk("coinc_step", {31'd0, step_o}, 32'd1);
    chk("coinc_out", out_o, 32'h1234_5678);
    tick(16);
    chk("coinc_hold", out_o, 32'h1234_5678);
    chk("coinc_pulses", pulses, 15);

    do_step(1'b1, 4, 1'b1, 20, "to00");
    chk("to00_out", out_o, 32'h1234_5679);
    chk("to00_ab", {30'd0, cur_ab}, 32'd0);
    a_i = 1'b1; b_i = 1'b1; cur_ab = 2'b11;
    tick(20);
    chk("err_set", {31'd0, err_o}, 32'd1);
    chk("err_out", out_o, 32'h1234_5679);
    chk("err_pulses", pulses, 16);
    SETP = 32'd37; SETP_WSTB = 1'b1; tick(1); SETP_WSTB = 1'b0; tick(1);
    chk("err_clr", {31'd0, err_o}, 32'd0);
    chk("setp37", out_o, 32'd37);

    RST_ON_Z = 1'b1; z_i = 1'b1;
    tick(20);
    chk("z_zero", out_o, 32'd0);
    z_i = 1'b0; tick(5); RST_ON_Z = 1'b0;

    FILTER = 4'd5;
    tick(2);
    a_i = 1'b0; tick(4); a_i = 1'b1;
    tick(20);
    chk("glitch_out", out_o, 32'd0);
    chk("glitch_pulses", pulses, 16);
    do_step(1'b1, 9, 1'b1, 20, "filt");
    chk("filt_out", out_o, 32'd1);
    FILTER = 4'd0;
    tick(2);

    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) do_step(1'b1, 4, 1'b0, 20, "dis");
    chk("dis_out", out_o, 32'd1);
    chk("dis_pulses", pulses, 17);
    enable_i = 1'b1;
    tick(5);
    do_step(1'b1, 4, 1'b1, 20, "reen");
    chk("reen_out", out_o, 32'd2);
    chk("reen_pulses", pulses, 18);

    SETP = 32'd0; SETP_WSTB = 1'b1; tick(1); SETP_WSTB = 1'b0; tick(1);
    do_step(1'b0, 4, 1'b1, 20, "under");
    chk("under_out", out_o, 32'hFFFF_FFFF);
    chk("under_dir", {31'd0, dir_o}, 32'd0);

`ifdef QDEC_PERIOD_EN
    for (int i = 0; i < 3; i++) do_step(1'b1, 4, 1'b1, 40, "per");
    chk("per_out", out_o, 32'd2);
    chk("period", period_o, 32'd40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
